// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// state codes and CLAIM/CTRL field positions.
// Optional feature macro: IRQ_EDGE_EN (per-source edge mode in CTRL[13:8]).
package irq_controller_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HWINT_W = 6;

  // Word offsets inside the 16-byte window (PrAddr[3:2])
  localparam logic [1:0] IRQ_MASK  = 2'd0;
  localparam logic [1:0] IRQ_PEND  = 2'd1;
  localparam logic [1:0] IRQ_CLAIM = 2'd2;
  localparam logic [1:0] IRQ_CTRL  = 2'd3;

  // Field positions
  localparam int unsigned CLAIM_VALID_BIT = 31;
  localparam int unsigned CTRL_GEN_BIT    = 0;
  localparam int unsigned CTRL_EDGE_LSB   = 8;
  localparam int unsigned CTRL_EDGE_MSB   = 13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_src_cond.sv
// Per-source request qualifier: level (src high) or edge (src rose since
// the previous cycle). Edge history exists only when IRQ_EDGE_EN is defined.
// Ports: clk, rst_n (synchronous, active-low), src (raw line),
//        edge_mode (1 = edge qualify), cond_c (combinational set request).
module irq_src_cond
  import irq_controller_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic edge_mode,
  output logic cond_c
);

`ifdef IRQ_EDGE_EN
  logic prev_q;
  logic prev_d;

  assign prev_d = src;

  // History clears on reset so a line held high yields one edge afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  always_comb begin
    cond_c = src;
    if (edge_mode) cond_c = src & ~prev_q;
  end
`else
  logic unused_sig;
  assign unused_sig = clk ^ rst_n ^ edge_mode;
  assign cond_c     = src;
`endif

endmodule

// File: rtl/irq_controller.sv
// Programmable interrupt controller: latches device requests, masks them,
// picks the lowest-index enabled source and presents it one-hot on HWInt,
// with a claim (read CLAIM) / complete (write CLAIM) handshake.
// Ports: Clock, Reset (synchronous, active-low), Src[N_SRC] raw IRQ lines,
//        Sel/PrAddr/PrWe/PrRe/PrWd bus slave inputs, PrRd combinational
//        read data (0 when Sel=0), HWInt registered one-hot request.
// Optional feature macro: IRQ_EDGE_EN (CTRL[13:8] per-source edge mode).
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned N_SRC = 6,
  parameter int unsigned ID_W  = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N_SRC-1:0]     Src,
  input  logic                 Sel,
  input  logic [1:0]           PrAddr,
  input  logic                 PrWe,
  input  logic                 PrRe,
  input  logic [DATA_W-1:0]    PrWd,
  output logic [DATA_W-1:0]    PrRd,
  output logic [HWINT_W-1:0]   HWInt
);

  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   pend_clr_c;
  logic [N_SRC-1:0]   cond_c;
  logic [N_SRC-1:0]   edge_mode_c;
  logic               gen_q, gen_d;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    insvc_q, insvc_d;
  logic [HWINT_W-1:0] hwint_q, hwint_d;

  logic               wr_mask_c, wr_pend_c, wr_ctrl_c;
  logic               claim_c, complete_c;
  logic               win_valid_c;
  logic [ID_W-1:0]    win_id_c;
  logic               unused_wd;

  assign unused_wd = ^PrWd;

  // Bus decode
  assign wr_mask_c  = Sel & PrWe & (PrAddr == IRQ_MASK);
  assign wr_pend_c  = Sel & PrWe & (PrAddr == IRQ_PEND);
  assign wr_ctrl_c  = Sel & PrWe & (PrAddr == IRQ_CTRL);
  assign claim_c    = Sel & PrRe & (PrAddr == IRQ_CLAIM) & (state_q == ASSERT);
  assign complete_c = Sel & PrWe & (PrAddr == IRQ_CLAIM) & (state_q == SERVICE) &
                      (PrWd[ID_W-1:0] == insvc_q);

`ifdef IRQ_EDGE_EN
  logic [N_SRC-1:0] edge_q, edge_d;

  always_comb begin
    edge_d = edge_q;
    if (wr_ctrl_c) edge_d = PrWd[CTRL_EDGE_LSB +: N_SRC];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) edge_q <= '0;
    else        edge_q <= edge_d;
  end

  assign edge_mode_c = edge_q;
`else
  assign edge_mode_c = '0;
`endif

  // One qualifier per source
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    irq_src_cond u_cond (
      .clk       (Clock),
      .rst_n     (Reset),
      .src       (Src[i]),
      .edge_mode (edge_mode_c[i]),
      .cond_c    (cond_c[i])
    );
  end

  // Fixed priority: lowest enabled pending index wins, gated by GEN
  always_comb begin
    win_valid_c = 1'b0;
    win_id_c    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (gen_q && pend_q[i] && mask_q[i]) begin
        win_valid_c = 1'b1;
        win_id_c    = ID_W'(i);
      end
    end
  end

  // Register file next state; a new request beats a same-cycle clear
  always_comb begin
    mask_d = mask_q;
    if (wr_mask_c) mask_d = PrWd[N_SRC-1:0];
    gen_d = gen_q;
    if (wr_ctrl_c) gen_d = PrWd[CTRL_GEN_BIT];
    pend_clr_c = '0;
    if (wr_pend_c) pend_clr_c = PrWd[N_SRC-1:0];
    if (claim_c)   pend_clr_c = pend_clr_c | (N_SRC'(1) << id_q);
    pend_d = (pend_q & ~pend_clr_c) | cond_c;
  end

  // FSM next state and HWInt
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    insvc_d = insvc_q;
    hwint_d = '0;
    case (state_q)
      IDLE: begin
        if (win_valid_c) begin
          state_d = ASSERT;
          id_d    = win_id_c;
          hwint_d = HWINT_W'(1) << win_id_c;
        end
      end
      ASSERT: begin
        hwint_d = hwint_q;
        if (claim_c) begin
          state_d = SERVICE;
          insvc_d = id_q;
          hwint_d = '0;
        end else if (!(gen_d && mask_d[id_q])) begin
          // Withdraw as soon as the mask/GEN write commits
          state_d = IDLE;
          hwint_d = '0;
        end
      end
      SERVICE: begin
        if (complete_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      mask_q  <= '0;
      pend_q  <= '0;
      gen_q   <= 1'b0;
      state_q <= IDLE;
      id_q    <= '0;
      insvc_q <= '0;
      hwint_q <= '0;
    end else begin
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      gen_q   <= gen_d;
      state_q <= state_d;
      id_q    <= id_d;
      insvc_q <= insvc_d;
      hwint_q <= hwint_d;
    end
  end

  assign HWInt = hwint_q;

  // Read mux; a CLAIM read only shows the valid ID when it is an actual claim
  always_comb begin
    PrRd = '0;
    if (Sel) begin
      case (PrAddr)
        IRQ_MASK: PrRd = DATA_W'(mask_q);
        IRQ_PEND: PrRd = DATA_W'(pend_q);
        IRQ_CLAIM: begin
          if (claim_c) begin
            PrRd                  = DATA_W'(id_q);
            PrRd[CLAIM_VALID_BIT] = 1'b1;
          end
        end
        IRQ_CTRL: begin
          PrRd[CTRL_GEN_BIT] = gen_q;
`ifdef IRQ_EDGE_EN
          PrRd[CTRL_EDGE_LSB +: N_SRC] = edge_q;
`endif
        end
        default: PrRd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations plus
// a per-cycle comparison of HWInt/PrRd against a behavioural model.
module tb_irq_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [5:0]  Src;
  logic        Sel, PrWe, PrRe;
  logic [1:0]  PrAddr;
  logic [31:0] PrWd;
  logic [31:0] PrRd;
  logic [5:0]  HWInt;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(.N_SRC(6), .ID_W(3)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Src    (Src),
    .Sel    (Sel),
    .PrAddr (PrAddr),
    .PrWe   (PrWe),
    .PrRe   (PrRe),
    .PrWd   (PrWd),
    .PrRd   (PrRd),
    .HWInt  (HWInt)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: m_req = source being presented (-1 none),
  // m_svc = source in service (-1 none)
  logic [5:0] m_mask, m_pend, m_edge, m_prev;
  logic       m_gen;
  int         m_req = -1;
  int         m_svc = -1;
  bit         m_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic       b_wr, b_rd;
    logic [5:0] cond, clr, n_mask;
    logic       n_gen;
    int         win;
    if (!Reset) begin
      m_mask = '0; m_pend = '0; m_edge = '0; m_prev = '0; m_gen = 1'b0;
      m_req = -1; m_svc = -1; m_valid = 1;
      return;
    end
    b_wr = Sel && PrWe;
    b_rd = Sel && PrRe;
    for (int i = 0; i < 6; i++)
      cond[i] = m_edge[i] ? (Src[i] && !m_prev[i]) : Src[i];
    win = -1;
    if (m_gen)
      for (int i = 5; i >= 0; i--)
        if (m_pend[i] && m_mask[i]) win = i;
    n_mask = (b_wr && PrAddr == 2'd0) ? PrWd[5:0] : m_mask;
    n_gen  = (b_wr && PrAddr == 2'd3) ? PrWd[0]   : m_gen;
    clr    = (b_wr && PrAddr == 2'd1) ? PrWd[5:0] : 6'd0;
    if (m_svc >= 0) begin
      if (b_wr && PrAddr == 2'd2 && int'(PrWd[2:0]) == m_svc) m_svc = -1;
    end else if (m_req >= 0) begin
      if (b_rd && PrAddr == 2'd2) begin
        clr[m_req] = 1'b1;
        m_svc = m_req;
        m_req = -1;
      end else if (!(n_gen && n_mask[m_req])) begin
        m_req = -1;
      end
    end else if (win >= 0) begin
      m_req = win;
    end
`ifdef IRQ_EDGE_EN
    if (b_wr && PrAddr == 2'd3) m_edge = PrWd[13:8];
`endif
    m_pend = (m_pend & ~clr) | cond;
    m_mask = n_mask;
    m_gen  = n_gen;
    m_prev = Src;
  endtask

  function automatic logic [31:0] exp_hwint();
    return (m_req >= 0) ? 32'(1) << m_req : 32'd0;
  endfunction

  function automatic logic [31:0] exp_prrd();
    if (!Sel) return 32'd0;
    case (PrAddr)
      2'd0: return 32'(m_mask);
      2'd1: return 32'(m_pend);
      2'd2: return (PrRe && m_req >= 0) ? (32'h8000_0000 | 32'(m_req)) : 32'd0;
      default: return (32'(m_edge) << 8) | 32'(m_gen);
    endcase
  endfunction

  initial forever begin
    @(posedge Clock);
    model_step();
  end

  // Per-cycle comparison, mid-cycle
  initial forever begin
    @(negedge Clock);
    if (m_valid) begin
      check("model_hwint", 32'(HWInt), exp_hwint());
      check("model_prrd", PrRd, exp_prrd());
    end
  end

  task automatic bus_idle();
    Sel = 1'b0; PrWe = 1'b0; PrRe = 1'b0; PrAddr = 2'd0; PrWd = 32'd0;
  endtask

  task automatic cycle();
    @(posedge Clock);
    #2;
    bus_idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Sel = 1'b1; PrWe = 1'b1; PrAddr = a; PrWd = d;
    cycle();
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    Sel = 1'b1; PrRe = 1'b1; PrAddr = a;
    #1;
    check(name, PrRd, exp);
    cycle();
  endtask

  task automatic hw_check(input string name, input logic [5:0] exp);
    check(name, 32'(HWInt), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with all lines high
    Reset = 1'b0; Src = 6'h3F; bus_idle();
    cycle(); cycle();
    hw_check("rst_hwint", 6'd0);
    rd_check("rst_pend", 2'd1, 32'd0);
    rd_check("rst_claim", 2'd2, 32'd0);
    Reset = 1'b1; Src = 6'd0;
    cycle();

    // Level request on source 1, claim, complete, re-assert
    wr(2'd0, 32'd3);
    wr(2'd3, 32'd1);
    Src = 6'b000010;
    cycle();
    hw_check("t2_lat1", 6'd0);
    cycle();
    hw_check("t2_lat2", 6'b000010);
    rd_check("t2_claim", 2'd2, 32'h8000_0001);
    hw_check("t2_svc", 6'd0);
    wr(2'd2, 32'd1);
    hw_check("t2_cmp1", 6'd0);
    cycle();
    hw_check("t2_cmp2", 6'b000010);
    Src = 6'd0;
    rd_check("t2_reclaim", 2'd2, 32'h8000_0001);
    wr(2'd2, 32'd1);

    // Simultaneous sources 0 and 1
    Src = 6'b000011;
    cycle(); cycle();
    hw_check("t3_hw", 6'b000001);
    Src = 6'd0;
    rd_check("t3_c0", 2'd2, 32'h8000_0000);
    wr(2'd2, 32'd0);
    cycle();
    rd_check("t3_c1", 2'd2, 32'h8000_0001);

    // Mismatched complete is ignored
    Src = 6'b000010;
    wr(2'd2, 32'd0);
    cycle();
    hw_check("t4_stay", 6'd0);
    rd_check("t4_claim0", 2'd2, 32'd0);
    wr(2'd2, 32'd1);
    cycle();
    hw_check("t4_back", 6'b000010);
    Src = 6'd0;
    rd_check("t4_reclaim", 2'd2, 32'h8000_0001);
    wr(2'd2, 32'd1);

    // Set beats W1C; mask drop in ASSERT withdraws
    Src = 6'b000001;
    wr(2'd1, 32'd1);
    rd_check("t6_pend", 2'd1, 32'd1);
    hw_check("t6_hw", 6'b000001);
    wr(2'd0, 32'd0);
    hw_check("t6_drop", 6'd0);
    rd_check("t6_idle", 2'd2, 32'd0);
    Src = 6'd0;
    wr(2'd1, 32'h3F);

    // Upper bits ignored; CTRL readback
    wr(2'd0, 32'hFFFF_FFFF);
    rd_check("mask_hi", 2'd0, 32'h3F);
    wr(2'd3, 32'hFFFF_FFFF);
`ifdef IRQ_EDGE_EN
    rd_check("ctrl_rb", 2'd3, 32'h3F01);
`else
    rd_check("ctrl_rb", 2'd3, 32'h0001);
`endif
    wr(2'd3, 32'd1);

    // GEN off blocks presentation, pending still latches
    wr(2'd3, 32'd0);
    Src = 6'h3F;
    cycle(); cycle();
    hw_check("gen_off", 6'd0);
    rd_check("gen_off_pend", 2'd1, 32'h3F);
    wr(2'd3, 32'd1);
    cycle();
    hw_check("gen_on", 6'b000001);
    Src = 6'd0;
    rd_check("gen_claim", 2'd2, 32'h8000_0000);
    wr(2'd0, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'h3F);

`ifdef IRQ_EDGE_EN
    // Edge mode: a held line claims once
    wr(2'd0, 32'd1);
    wr(2'd3, 32'h101);
    Src = 6'b000001;
    cycle(); cycle();
    hw_check("t5_hw", 6'b000001);
    rd_check("t5_claim", 2'd2, 32'h8000_0000);
    wr(2'd2, 32'd0);
    cycle();
    rd_check("t5_claim2", 2'd2, 32'd0);
    hw_check("t5_quiet", 6'd0);
    repeat (4) cycle();
    Src = 6'd0;
    wr(2'd3, 32'd1);
`endif

    // Mixed traffic against the model, with one mid-run reset
    for (int k = 0; k < 300; k++) begin
      Reset  = (k == 150) ? 1'b0 : 1'b1;
      Src    = 6'($urandom);
      Sel    = 1'($urandom_range(0, 1));
      PrWe   = 1'($urandom_range(0, 1));
      PrRe   = 1'($urandom_range(0, 1));
      PrAddr = 2'($urandom_range(0, 3));
      PrWd   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 7));
      @(posedge Clock);
      #2;
    end
    Reset = 1'b1;
    bus_idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
